// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
// Groups every signal between the memory bus arbiter and its surroundings:
// the instruction-fetch requester, the decoder data requester and the
// external memory port. Names keep the arbiter's point of view: i_* are
// arbiter inputs and o_* are arbiter outputs.
//   master : the arbiter itself (drives o_*, samples i_*)
//   slave  : requesters + memory model (drive i_*, sample o_*)
`timescale 1ns/1ps
interface mem_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  // fetch requester (read only)
  logic          i_f_req;
  logic [AW-1:0] i_f_addr;
  logic          o_f_gnt;
  logic          o_f_done;
  logic [DW-1:0] o_f_rdata;
  // data requester
  logic          i_d_req;
  logic          i_d_we;
  logic [AW-1:0] i_d_addr;
  logic [DW-1:0] i_d_wdata;
  logic          o_d_gnt;
  logic          o_d_done;
  logic [DW-1:0] o_d_rdata;
  // external memory
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_rd;
  logic          o_mem_wr;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ready;
  // status
  logic          o_err;
  logic [1:0]    o_state;

  modport master (
    input  i_f_req, i_f_addr,
    output o_f_gnt, o_f_done, o_f_rdata,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata,
    output o_d_gnt, o_d_done, o_d_rdata,
    output o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr,
    input  i_mem_rdata, i_mem_ready,
    output o_err, o_state
  );

  modport slave (
    output i_f_req, i_f_addr,
    input  o_f_gnt, o_f_done, o_f_rdata,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata,
    input  o_d_gnt, o_d_done, o_d_rdata,
    input  o_mem_addr, o_mem_wdata, o_mem_rd, o_mem_wr,
    output i_mem_rdata, i_mem_ready,
    input  o_err, o_state
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one memory port between the instruction-fetch path and the decoder
// data path. Data wins by default; a starvation counter forces fetch to win
// after STARVE_LIMIT consecutive data grants taken while fetch was waiting.
// Exactly one transaction is in flight; an access that sees no i_mem_ready
// for TIMEOUT cycles is aborted and completes with o_err.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    mem_bus_arbiter_if.master: fetch req/gnt/done/rdata, data
//          req/we/addr/wdata/gnt/done/rdata, memory addr/wdata/rd/wr/
//          rdata/ready, o_err and o_state (00 IDLE, 01 ACCESS_F, 10 ACCESS_D)
// All outputs come straight from registers.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mem_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_ACCESS_F = 2'b01,
    ST_ACCESS_D = 2'b10
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  // wait_cnt is 0 in the first ACCESS cycle, so this value marks the
  // TIMEOUT-th cycle spent waiting for ready.
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t        state_q,    state_d;
  logic [3:0]    starve_q,   starve_d;
  logic [7:0]    wait_q,     wait_d;
  logic          we_q,       we_d;
  logic [AW-1:0] addr_q,     addr_d;
  logic [DW-1:0] wdata_q,    wdata_d;
  logic          mem_rd_q,   mem_rd_d;
  logic          mem_wr_q,   mem_wr_d;
  logic          f_gnt_q,    f_gnt_d;
  logic          d_gnt_q,    d_gnt_d;
  logic          f_done_q,   f_done_d;
  logic          d_done_q,   d_done_d;
  logic          err_q,      err_d;
  logic [DW-1:0] f_rdata_q,  f_rdata_d;
  logic [DW-1:0] d_rdata_q,  d_rdata_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      starve_q  <= '0;
      wait_q    <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_rd_q  <= 1'b0;
      mem_wr_q  <= 1'b0;
      f_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      f_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      wait_q    <= wait_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mem_rd_q  <= mem_rd_d;
      mem_wr_q  <= mem_wr_d;
      f_gnt_q   <= f_gnt_d;
      d_gnt_q   <= d_gnt_d;
      f_done_q  <= f_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    wait_d    = wait_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    mem_rd_d  = mem_rd_q;
    mem_wr_d  = mem_wr_q;
    f_gnt_d   = 1'b0;
    d_gnt_d   = 1'b0;
    f_done_d  = 1'b0;
    d_done_d  = 1'b0;
    err_d     = 1'b0;
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        // Data has priority unless fetch has been passed over too often.
        if (bus.i_d_req && !(bus.i_f_req && starve_q == STARVE_MAX)) begin
          state_d  = ST_ACCESS_D;
          d_gnt_d  = 1'b1;
          we_d     = bus.i_d_we;
          addr_d   = bus.i_d_addr;
          wdata_d  = bus.i_d_wdata;
          mem_rd_d = ~bus.i_d_we;
          mem_wr_d = bus.i_d_we;
          wait_d   = '0;
          if (bus.i_f_req && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (bus.i_f_req) begin
          state_d  = ST_ACCESS_F;
          f_gnt_d  = 1'b1;
          we_d     = 1'b0;
          addr_d   = bus.i_f_addr;
          wdata_d  = '0;
          mem_rd_d = 1'b1;
          mem_wr_d = 1'b0;
          wait_d   = '0;
          starve_d = '0;
        end
      end

      ST_ACCESS_F, ST_ACCESS_D: begin
        // A ready on the last allowed cycle still completes normally.
        if (bus.i_mem_ready || wait_q == WAIT_LAST) begin
          state_d  = ST_IDLE;
          wait_d   = '0;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          err_d    = ~bus.i_mem_ready;
          if (state_q == ST_ACCESS_F) begin
            f_done_d  = 1'b1;
            f_rdata_d = bus.i_mem_ready ? bus.i_mem_rdata : '0;
          end else begin
            d_done_d  = 1'b1;
            d_rdata_d = (bus.i_mem_ready && !we_q) ? bus.i_mem_rdata : '0;
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.o_f_gnt     = f_gnt_q;
  assign bus.o_f_done    = f_done_q;
  assign bus.o_f_rdata   = f_rdata_q;
  assign bus.o_d_gnt     = d_gnt_q;
  assign bus.o_d_done    = d_done_q;
  assign bus.o_d_rdata   = d_rdata_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_mem_rd    = mem_rd_q;
  assign bus.o_mem_wr    = mem_wr_q;
  assign bus.o_err       = err_q;
  assign bus.o_state     = state_q;

endmodule
